irq_pending_ctrl: RTL and testbench

Interrupt pending/mask controller that sits directly upstream of `p_encoder_8_3`. It captures rising edges on eight request lines into a pending register and presents the unmasked pending vector to the encoder as `in`/`en`. It then takes the encoder's `v_out`/`out` back, latches the winning index, and runs a request/acknowledge handshake with the CPU. On acknowledge it clears the serviced pending bit.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_edge_detect.sv | 28 ++
 rtl/p_encoder_8_3.sv | 17 +
 rtl/irq_pending_ctrl.sv | 94 +++++++++
 tb/tb_irq_pending_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending/mask controller.
package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  // Decode a line index to a one-hot line vector.
  function automatic logic [N_IRQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_IRQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the raw request lines.
// IRQ_LEVEL_MODE_EN: pass the lines straight through (level sensitivity, no delay register).
module irq_edge_detect #(
  parameter int N_IRQ = irq_pkg::N_IRQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] rise
);

`ifdef IRQ_LEVEL_MODE_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign rise           = irq_in;
`else
  logic [N_IRQ-1:0] irq_in_d;

  // Reset to 0 so a line held high through reset counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) irq_in_d <= '0;
    else     irq_in_d <= irq_in;
  end

  assign rise = irq_in & ~irq_in_d;
`endif

endmodule

// File: rtl/p_encoder_8_3.sv
// 8-to-3 priority encoder: reports the index of the highest set input bit.
module p_encoder_8_3 (
  input  logic       en,
  input  logic [7:0] in,
  output logic       v_out,
  output logic [2:0] out
);

  always_comb begin
    out   = 3'd0;
    v_out = en & (|in);
    for (int i = 0; i < 8; i++) begin
      if (in[i]) out = 3'(i);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask controller feeding an external priority encoder
// and running a request/acknowledge handshake with the CPU.
// Optional IRQ_LEVEL_MODE_EN selects level-sensitive capture (see irq_edge_detect).
module irq_pending_ctrl #(
  parameter int N_IRQ = irq_pkg::N_IRQ,
  parameter int IDX_W = irq_pkg::IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic                mask_wr,
  input  logic [N_IRQ-1:0]    mask_data,
  output logic                enc_en,
  output logic [N_IRQ-1:0]    enc_in,
  input  logic                enc_v,
  input  logic [IDX_W-1:0]    enc_idx,
  output logic                irq,
  output logic [IDX_W-1:0]    vec,
  input  logic                ack,
  output logic [N_IRQ-1:0]    pending,
  output irq_pkg::irq_state_t dbg_state
);

  import irq_pkg::*;

  // Handshake: irq rises one cycle after the state enters ASSERT decision and
  // stays high until ack is sampled in ASSERT; ack in any other state is ignored.

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] clr;
  logic [IDX_W-1:0] vec_q;
  logic [IDX_W-1:0] vec_d;
  logic             irq_q;
  irq_state_t       state_q;
  irq_state_t       state_d;

  irq_edge_detect #(
    .N_IRQ (N_IRQ)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .rise   (rise)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (enc_v) begin
          vec_d   = enc_idx;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (ack) begin
          clr     = N_IRQ'(idx_to_onehot(IDX_W'(vec_q)));
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      irq_q     <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      irq_q     <= (state_d == ASSERT);
      // A new edge on the bit being cleared wins: it is a new request.
      pending_q <= (pending_q & ~clr) | rise;
      if (mask_wr) mask_q <= mask_data;
    end
  end

  assign enc_en    = (state_q == IDLE);
  assign enc_in    = pending_q & ~mask_q;
  assign irq       = irq_q;
  assign vec       = vec_q;
  assign pending   = pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl with the priority encoder in the loop.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       enc_en;
  logic [7:0] enc_in;
  logic       enc_v;
  logic [2:0] enc_idx;
  logic       irq;
  logic [2:0] vec;
  logic       ack;
  logic [7:0] pending;
  irq_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .enc_en    (enc_en),
    .enc_in    (enc_in),
    .enc_v     (enc_v),
    .enc_idx   (enc_idx),
    .irq       (irq),
    .vec       (vec),
    .ack       (ack),
    .pending   (pending),
    .dbg_state (dbg_state)
  );

  p_encoder_8_3 u_enc (
    .en    (enc_en),
    .in    (enc_in),
    .v_out (enc_v),
    .out   (enc_idx)
  );

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wr   = 1'b1;
    mask_data = m;
    tick();
    mask_wr   = 1'b0;
  endtask

  task automatic pulse_lines(input logic [7:0] v);
    irq_in = v;
    tick();
    irq_in = 8'h00;
  endtask

  // Ack in ASSERT, then walk through HOLDOFF back to IDLE.
  task automatic do_ack(input string tag, input logic [7:0] exp_pend);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_pend"}, 32'(pending), 32'(exp_pend));
    check({tag, "_irq_lo"}, 32'(irq), 32'd0);
    check({tag, "_holdoff"}, 32'(dbg_state), 32'(HOLDOFF));
    tick();
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic expect_assert(input string tag, input logic [2:0] exp_vec);
    tick();
    check({tag, "_irq"}, 32'(irq), 32'd1);
    check({tag, "_vec"}, 32'(vec), 32'(exp_vec));
  endtask

  // ---------------- stimulus
  initial begin
    rst       = 1'b1;
    irq_in    = 8'h00;
    mask_wr   = 1'b0;
    mask_data = 8'h00;
    ack       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pend", 32'(pending), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check("idle_quiet", 32'(irq), 32'd0);

`ifndef IRQ_LEVEL_MODE_EN
    // Single pulse on line 2.
    pulse_lines(8'h04);
    check("t1_pend", 32'(pending), 32'h04);
    check("t1_irq_lat", 32'(irq), 32'd0);
    expect_assert("t1", 3'd2);
    do_ack("t1", 8'h00);
    tick();
    check("t1_no_irq", 32'(irq), 32'd0);

    // Simultaneous edges served highest first.
    exp_q = {3'd7, 3'd5, 3'd3, 3'd2};
    pulse_lines(8'hAC);
    check("t2_pend", 32'(pending), 32'hAC);
    begin
      logic [7:0] exp_pend;
      logic [2:0] ev;
      exp_pend = 8'hAC;
      while (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        expect_assert("t2", ev);
        exp_pend[ev] = 1'b0;
        do_ack("t2", exp_pend);
      end
    end
    tick();
    check("t2_empty_irq", 32'(irq), 32'd0);
    check("t2_empty_pend", 32'(pending), 32'h00);

    // Masked line stays pending but hidden.
    write_mask(8'h80);
    pulse_lines(8'h81);
    check("t3_pend", 32'(pending), 32'h81);
    expect_assert("t3", 3'd0);
    do_ack("t3", 8'h80);
    tick();
    check("t3_masked_irq", 32'(irq), 32'd0);
    check("t3_masked_enc", 32'(enc_in), 32'h00);
    write_mask(8'h00);
    expect_assert("t3u", 3'd7);
    do_ack("t3u", 8'h00);

    // Edge on the serviced line in the ack cycle: set wins.
    pulse_lines(8'h08);
    expect_assert("t4", 3'd3);
    ack    = 1'b1;
    irq_in = 8'h08;
    tick();
    ack    = 1'b0;
    irq_in = 8'h00;
    check("t4_setwin_pend", 32'(pending), 32'h08);
    check("t4_irq_lo", 32'(irq), 32'd0);
    tick();
    expect_assert("t4r", 3'd3);
    do_ack("t4r", 8'h00);
`else
    // Held level re-raises the same request after every ack.
    irq_in = 8'h02;
    tick();
    check("lv_pend", 32'(pending), 32'h02);
    expect_assert("lv0", 3'd1);
    for (int i = 0; i < 3; i++) begin
      do_ack("lv", 8'h02);
      expect_assert("lvr", 3'd1);
    end
    irq_in = 8'h00;
    do_ack("lv_drop", 8'h00);
    tick();
    tick();
    check("lv_quiet", 32'(irq), 32'd0);
`endif

    // Reset in the middle of a handshake.
    irq_in = 8'h18;
    tick();
    irq_in = 8'h00;
    expect_assert("t5", 3'd4);
    check("t5_pend", 32'(pending), 32'h18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_irq", 32'(irq), 32'd0);
    check("t5_pend0", 32'(pending), 32'h00);
    check("t5_vec", 32'(vec), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("stray_ack_state", 32'(dbg_state), 32'(IDLE));
    check("stray_ack_pend", 32'(pending), 32'h00);
    check("stray_ack_irq", 32'(irq), 32'd0);

    // Line held high through reset release is a first-cycle request.
    irq_in = 8'h01;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("hold_rst_pend", 32'(pending), 32'h01);
    expect_assert("hold_rst", 3'd0);
    irq_in = 8'h00;
    do_ack("hold_rst", 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
